fifo_mc_reg: RTL and testbench
==============================

Name: fifo_mc_reg

Overview:
- Multi-channel register-based FIFO bank: NUM_CH independent queues, each 2**ADDR_BW entries deep and DATA_BW wide.
- Successor to the externally-pointered register FIFO: pointer, count and flag logic now live inside the block.
- Per-channel push/pop handshake with full/empty/almost-full status.
- Sits between EDU pipeline stages wherever several lanes need independent decoupling buffers.

Parameters:
NUM_CH, 4, number of independent channels
ADDR_BW, 2, log2 of per-channel depth (depth = 2**ADDR_BW)
DATA_BW, 8, entry width in bits
AFULL_TH, 3, almost_full asserts when num_item >= AFULL_TH (1..2**ADDR_BW)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
push  input  NUM_CH  per-channel write request
pop  input  NUM_CH  per-channel read request (consumes the entry currently on dout)
din  input  NUM_CH*DATA_BW  write data; channel c at [c*DATA_BW +: DATA_BW]
dout  output  NUM_CH*DATA_BW  head entry per channel, same packing
num_item  output  NUM_CH*(ADDR_BW+1)  occupancy per channel, 0..2**ADDR_BW
full  output  NUM_CH  num_item == 2**ADDR_BW
empty  output  NUM_CH  num_item == 0
almost_full  output  NUM_CH  num_item >= AFULL_TH
ovf  output  NUM_CH  sticky overflow flag (optional feature)
udf  output  NUM_CH  sticky underflow flag (optional feature)

Behaviour:
- Reset (rst=1 at posedge): every storage entry of every channel cleared to 0 (all 2**ADDR_BW entries, none skipped); wr_ptr=rd_ptr=0; num_item=0; ovf=udf=0. Post-reset outputs: dout=0, empty=all 1s, full=0, almost_full=0.
- rst dominates push/pop in the same cycle; reset mid-operation discards all contents.
- Channels are fully independent; no cross-channel arbitration.
- Status outputs and dout are registered-state decodes: combinational from pointers and count, no input-to-output path.
- dout: storage[rd_ptr] when num_item != 0, else 0.
- Accepted push: (push & ~full) | (push & pop & full).
  - Writes din to storage[wr_ptr].
  - wr_ptr increments modulo 2**ADDR_BW (natural wrap).
- Accepted pop: pop & ~empty.
  - rd_ptr increments modulo 2**ADDR_BW.
  - The popped data is the dout value in that same cycle.
- num_item next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push+pop:
  - Full: both accepted; count stays 2**ADDR_BW.
  - Empty: push accepted, pop ignored; no bypass, so the new entry appears on dout next cycle.
  - Otherwise: both accepted.
- Push while full without pop: dropped; storage and pointers unchanged.
- Pop while empty: ignored.
- Write latency: 1 cycle from accepted push to entry visible on dout (when the queue was empty).

Optional Feature:
- Macro: FIFO_MC_ERRFLAG_EN.
- Defined:
  - ovf[c] sets on a dropped push (push & full & ~pop).
  - udf[c] sets on pop & empty.
  - Both are sticky until rst.
- Undefined: ovf and udf are tied to 0; no flag registers are synthesised.
- Ports exist in both builds.

Decomposition:
- Shared package/header (fifo_pkg): depth derivation constant, channel slice-width helpers for packed-bus indexing, default parameter values.
- One sub-module, fifo_mc_ch: single-channel core holding storage, pointers, count, flags and status.
- Instantiated NUM_CH times in a generate loop; top level only slices buses.

Test Plan:
- Reset then idle: rst high 1 cycle → all empty=1, num_item=0, dout=0, ovf=udf=0 on every channel.
- Ch0 push 0x11,0x22,0x33,0x44 (ADDR_BW=2) → after 3rd push almost_full[0]=1; after 4th full[0]=1, num_item=4; other channels untouched.
- Ch0 full, push 0x55 without pop → data dropped, num_item stays 4; pop×4 returns 0x11,0x22,0x33,0x44; ovf[0]=1 only with FIFO_MC_ERRFLAG_EN.
- Ch1 wrap: push/pop alternating 10 entries 0xA0..0xA9 → output order preserved across pointer wrap; num_item never exceeds 1.
- Simultaneous push+pop on full ch2 → count stays 4, head advances, new data appears at tail. On empty ch3: push 0x7E + pop → num_item=1, dout=0x7E next cycle; udf[3]=1 with flag macro.
- Reset mid-stream with ch0 holding 2 entries and push asserted → next cycle num_item=0, dout=0, pushed data discarded.

Source files
------------

// File: rtl/fifo_mc_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_mc_reg_pkg
//  Purpose : Shared definitions for the multi-channel register FIFO bank:
//            default parameter values, per-channel depth derivation and
//            packed-bus slice helpers used by the top level.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package fifo_mc_reg_pkg;

   localparam int c_DEF_NUM_CH   = 4;
   localparam int c_DEF_ADDR_BW  = 2;
   localparam int c_DEF_DATA_BW  = 8;
   localparam int c_DEF_AFULL_TH = 3;

   // Number of entries held by one channel.
   function automatic int fifo_depth(input int addr_bw);
      return 1 << addr_bw;
   endfunction

   // LSB position of channel ch inside a bus packing w bits per channel.
   function automatic int ch_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mc_reg_ch.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_mc_ch
//  Purpose : Single-channel register FIFO core: storage, read/write pointers,
//            occupancy count, status decodes and optional sticky error flags.
//  Ports   : clk, rst        - clock, synchronous active-high reset
//            push, pop       - write / read request
//            din             - write data
//            dout            - head entry (0 when empty)
//            num_item        - occupancy 0..2**ADDR_BW
//            full, empty     - occupancy decodes
//            almost_full     - num_item >= AFULL_TH
//            ovf, udf        - sticky overflow / underflow flags
//  Config  : FIFO_MC_ERRFLAG_EN enables the ovf/udf flag registers;
//            otherwise both outputs are tied low.
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_mc_ch
   import fifo_mc_reg_pkg::*;
#(
   parameter int ADDR_BW  = c_DEF_ADDR_BW,
   parameter int DATA_BW  = c_DEF_DATA_BW,
   parameter int AFULL_TH = c_DEF_AFULL_TH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [DATA_BW-1:0] din,
   output logic [DATA_BW-1:0] dout,
   output logic [ADDR_BW:0]   num_item,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               ovf,
   output logic               udf
);

   localparam int              c_DEPTH    = fifo_depth(ADDR_BW);
   localparam logic [ADDR_BW:0] c_FULL_CNT = (ADDR_BW+1)'(c_DEPTH);
   localparam logic [ADDR_BW:0] c_AFULL    = (ADDR_BW+1)'(AFULL_TH);

   logic [DATA_BW-1:0] r_mem [c_DEPTH];
   logic [ADDR_BW-1:0] r_wr_ptr;
   logic [ADDR_BW-1:0] r_rd_ptr;
   logic [ADDR_BW:0]   r_cnt;

   logic w_full;
   logic w_empty;
   logic w_push_acc;
   logic w_pop_acc;

   assign w_full     = (r_cnt == c_FULL_CNT);
   assign w_empty    = (r_cnt == '0);
   // A full queue still accepts a push when a pop frees the head slot in the
   // same cycle; an empty queue never forwards push data to pop (no bypass).
   assign w_push_acc = push & (~w_full | pop);
   assign w_pop_acc  = pop & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push_acc) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push_acc && !w_pop_acc) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (w_pop_acc && !w_push_acc) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign dout        = w_empty ? '0 : r_mem[r_rd_ptr];
   assign num_item    = r_cnt;
   assign full        = w_full;
   assign empty       = w_empty;
   assign almost_full = (r_cnt >= c_AFULL);

`ifdef FIFO_MC_ERRFLAG_EN
   logic r_ovf;
   logic r_udf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (push && w_full && !pop) begin
            r_ovf <= 1'b1;
         end
         if (pop && w_empty) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`else
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_mc_reg.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_mc_reg
//  Purpose : Bank of NUM_CH independent register FIFOs, each 2**ADDR_BW deep
//            and DATA_BW wide. The top level only slices the packed buses
//            and replicates the single-channel core.
//  Ports   : clk, rst          - clock, synchronous active-high reset
//            push[NUM_CH]      - per-channel write request
//            pop[NUM_CH]       - per-channel read request
//            din               - channel c at [c*DATA_BW +: DATA_BW]
//            dout              - head entry per channel, same packing
//            num_item          - channel c at [c*(ADDR_BW+1) +: ADDR_BW+1]
//            full, empty, almost_full, ovf, udf - per-channel status
//  Config  : FIFO_MC_ERRFLAG_EN enables sticky ovf/udf flags in every
//            channel; otherwise they read 0.
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_mc_reg
   import fifo_mc_reg_pkg::*;
#(
   parameter int NUM_CH   = c_DEF_NUM_CH,
   parameter int ADDR_BW  = c_DEF_ADDR_BW,
   parameter int DATA_BW  = c_DEF_DATA_BW,
   parameter int AFULL_TH = c_DEF_AFULL_TH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             push,
   input  logic [NUM_CH-1:0]             pop,
   input  logic [NUM_CH*DATA_BW-1:0]     din,
   output logic [NUM_CH*DATA_BW-1:0]     dout,
   output logic [NUM_CH*(ADDR_BW+1)-1:0] num_item,
   output logic [NUM_CH-1:0]             full,
   output logic [NUM_CH-1:0]             empty,
   output logic [NUM_CH-1:0]             almost_full,
   output logic [NUM_CH-1:0]             ovf,
   output logic [NUM_CH-1:0]             udf
);

   localparam int c_CNT_BW = ADDR_BW + 1;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fifo_mc_ch #(
         .ADDR_BW  (ADDR_BW),
         .DATA_BW  (DATA_BW),
         .AFULL_TH (AFULL_TH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .push        (push[c]),
         .pop         (pop[c]),
         .din         (din[ch_lsb(c, DATA_BW) +: DATA_BW]),
         .dout        (dout[ch_lsb(c, DATA_BW) +: DATA_BW]),
         .num_item    (num_item[ch_lsb(c, c_CNT_BW) +: c_CNT_BW]),
         .full        (full[c]),
         .empty       (empty[c]),
         .almost_full (almost_full[c]),
         .ovf         (ovf[c]),
         .udf         (udf[c])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_mc_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fifo_mc_reg
//  Purpose : Self-checking bench for fifo_mc_reg (default parameters) using
//            directed scenarios plus randomized traffic against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_mc_reg;

   localparam int NUM_CH   = 4;
   localparam int ADDR_BW  = 2;
   localparam int DATA_BW  = 8;
   localparam int AFULL_TH = 3;
   localparam int DEPTH    = 4;
`ifdef FIFO_MC_ERRFLAG_EN
   localparam bit c_ERR_EN = 1'b1;
`else
   localparam bit c_ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  push;
   logic [3:0]  pop;
   logic [31:0] din;
   logic [31:0] dout;
   logic [11:0] num_item;
   logic [3:0]  full, empty, almost_full, ovf, udf;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: one queue per channel plus sticky flags.
   logic [7:0] q [NUM_CH][$];
   logic [3:0] m_ovf = '0;
   logic [3:0] m_udf = '0;

   fifo_mc_reg #(
      .NUM_CH(NUM_CH), .ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW), .AFULL_TH(AFULL_TH)
   ) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
      .dout(dout), .num_item(num_item), .full(full), .empty(empty),
      .almost_full(almost_full), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] put(input int c, input logic [7:0] v);
      return 32'(v) << (c * 8);
   endfunction

   function automatic logic [7:0] m_head(input int c);
      return (q[c].size() != 0) ? q[c][0] : 8'h00;
   endfunction

   // Drive one clock cycle and advance the model with the same stimulus.
   task automatic cycle(input logic r, input logic [3:0] pu, input logic [3:0] po,
                        input logic [31:0] d);
      rst = r; push = pu; pop = po; din = d;
      @(posedge clk);
      if (r) begin
         for (int c = 0; c < NUM_CH; c++) q[c].delete();
         m_ovf = '0;
         m_udf = '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            int sz;
            bit is_full, is_empty, acc_push, acc_pop;
            sz       = q[c].size();
            is_full  = (sz == DEPTH);
            is_empty = (sz == 0);
            acc_push = pu[c] && (!is_full || po[c]);
            acc_pop  = po[c] && !is_empty;
            if (c_ERR_EN && pu[c] && is_full && !po[c]) m_ovf[c] = 1'b1;
            if (c_ERR_EN && po[c] && is_empty)          m_udf[c] = 1'b1;
            if (acc_pop)  void'(q[c].pop_front());
            if (acc_push) q[c].push_back(d[c*8 +: 8]);
         end
      end
      #1;
      rst = 1'b0; push = '0; pop = '0; din = '0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 4'h0, 4'h0, 32'h0);
      cycle(1'b0, 4'h0, 4'h0, 32'h0);
      n_total++;
      if (empty !== 4'hF) $display("FAIL reset_empty got %h exp f", empty); else n_pass++;
      n_total++;
      if (num_item !== 12'h0) $display("FAIL reset_num got %h exp 0", num_item); else n_pass++;
      n_total++;
      if (dout !== 32'h0) $display("FAIL reset_dout got %h exp 0", dout); else n_pass++;
      n_total++;
      if ({full, almost_full, ovf, udf} !== 16'h0)
         $display("FAIL reset_flags got %h exp 0", {full, almost_full, ovf, udf});
      else n_pass++;
   endtask

   task automatic test_fill();
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h11));
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h22));
      n_total++;
      if (almost_full[0] !== 1'b0) $display("FAIL fill_af2 got %b exp 0", almost_full[0]); else n_pass++;
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h33));
      n_total++;
      if ({almost_full[0], full[0]} !== 2'b10)
         $display("FAIL fill_af3 got %b exp 10", {almost_full[0], full[0]});
      else n_pass++;
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h44));
      n_total++;
      if ({full[0], num_item[2:0]} !== 4'b1100)
         $display("FAIL fill_full got %b exp 1100", {full[0], num_item[2:0]});
      else n_pass++;
      n_total++;
      if ({empty[3:1], num_item[11:3]} !== {3'b111, 9'h0})
         $display("FAIL fill_others got %h exp e00", {empty[3:1], num_item[11:3]});
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [7:0] exp_v [4];
      exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h55));
      n_total++;
      if (num_item[2:0] !== 3'd4) $display("FAIL ovf_num got %0d exp 4", num_item[2:0]); else n_pass++;
      n_total++;
      if (ovf[0] !== c_ERR_EN) $display("FAIL ovf_flag got %b exp %b", ovf[0], c_ERR_EN); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (dout[7:0] !== exp_v[i]) $display("FAIL ovf_pop%0d got %h exp %h", i, dout[7:0], exp_v[i]);
         else n_pass++;
         cycle(1'b0, 4'h0, 4'h1, 32'h0);
      end
      n_total++;
      if ({empty[0], dout[7:0]} !== 9'h100)
         $display("FAIL ovf_drained got %h exp 100", {empty[0], dout[7:0]});
      else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 4'h2, 4'h0, put(1, 8'hA0 + 8'(i)));
         n_total++;
         if ({num_item[5:3], dout[15:8]} !== {3'd1, 8'hA0 + 8'(i)})
            $display("FAIL wrap%0d got %h exp %h", i, {num_item[5:3], dout[15:8]}, {3'd1, 8'hA0 + 8'(i)});
         else n_pass++;
         cycle(1'b0, 4'h0, 4'h2, 32'h0);
      end
      n_total++;
      if (empty[1] !== 1'b1) $display("FAIL wrap_end got %b exp 1", empty[1]); else n_pass++;
   endtask

   task automatic test_simul();
      logic [7:0] exp_v [4];
      exp_v = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'h4, 4'h0, put(2, 8'hC0 + 8'(i)));
      cycle(1'b0, 4'h4, 4'h4, put(2, 8'hC4));
      n_total++;
      if ({full[2], num_item[8:6], dout[23:16]} !== {1'b1, 3'd4, 8'hC1})
         $display("FAIL simul_full got %h exp %h", {full[2], num_item[8:6], dout[23:16]}, {1'b1, 3'd4, 8'hC1});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (dout[23:16] !== exp_v[i]) $display("FAIL simul_pop%0d got %h exp %h", i, dout[23:16], exp_v[i]);
         else n_pass++;
         cycle(1'b0, 4'h0, 4'h4, 32'h0);
      end
      cycle(1'b0, 4'h8, 4'h8, put(3, 8'h7E));
      n_total++;
      if ({num_item[11:9], dout[31:24]} !== {3'd1, 8'h7E})
         $display("FAIL simul_empty got %h exp %h", {num_item[11:9], dout[31:24]}, {3'd1, 8'h7E});
      else n_pass++;
      n_total++;
      if (udf[3] !== c_ERR_EN) $display("FAIL simul_udf got %b exp %b", udf[3], c_ERR_EN); else n_pass++;
      cycle(1'b0, 4'h0, 4'h8, 32'h0);
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h5A));
      cycle(1'b0, 4'h1, 4'h0, put(0, 8'h5B));
      n_total++;
      if (num_item[2:0] !== 3'd2) $display("FAIL rstmid_pre got %0d exp 2", num_item[2:0]); else n_pass++;
      cycle(1'b1, 4'h1, 4'h0, put(0, 8'h5C));
      n_total++;
      if ({num_item, dout, empty, ovf, udf} !== {12'h0, 32'h0, 4'hF, 8'h0})
         $display("FAIL rstmid got num=%h dout=%h empty=%h ovf=%h udf=%h exp 0/0/f/0/0",
                  num_item, dout, empty, ovf, udf);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         logic [3:0] pu, po;
         logic [11:0] e_num;
         logic [31:0] e_dout;
         logic [3:0] e_full, e_empty, e_af;
         if ((n / 50) % 2 == 0) begin
            pu = 4'($urandom) | 4'($urandom);
            po = 4'($urandom) & 4'($urandom);
         end else begin
            pu = 4'($urandom) & 4'($urandom);
            po = 4'($urandom) | 4'($urandom);
         end
         cycle(($urandom_range(0, 99) == 0), pu, po, $urandom);
         for (int c = 0; c < NUM_CH; c++) begin
            e_num[c*3 +: 3]  = 3'(q[c].size());
            e_dout[c*8 +: 8] = m_head(c);
            e_full[c]        = (q[c].size() == DEPTH);
            e_empty[c]       = (q[c].size() == 0);
            e_af[c]          = (q[c].size() >= AFULL_TH);
         end
         n_total++;
         if (dout !== e_dout) $display("FAIL rand_dout c%0d got %h exp %h", n, dout, e_dout); else n_pass++;
         n_total++;
         if (num_item !== e_num) $display("FAIL rand_num c%0d got %h exp %h", n, num_item, e_num); else n_pass++;
         n_total++;
         if ({full, empty, almost_full} !== {e_full, e_empty, e_af})
            $display("FAIL rand_status c%0d got %h exp %h", n, {full, empty, almost_full}, {e_full, e_empty, e_af});
         else n_pass++;
         n_total++;
         if ({ovf, udf} !== {m_ovf, m_udf})
            $display("FAIL rand_flags c%0d got %h exp %h", n, {ovf, udf}, {m_ovf, m_udf});
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; push = '0; pop = '0; din = '0;
      test_reset();
      test_fill();
      test_overflow();
      test_wrap();
      test_simul();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
